alu_cmd_ctrl: RTL
=================

Name: alu_cmd_ctrl

Overview:
Command sequencer for the UART ALU. It sits between the uart_rx AXI-stream output and the uart_tx AXI-stream input. It collects a 3-byte command frame (opcode, A, B), runs one ALU operation, and streams back a 3-byte response frame (status, result_lo, result_hi). It also provides inter-byte timeout, frame-error abort and a completed-command counter.

Parameters:
DATA_WIDTH, 8, UART byte width; only 8 is supported; the result is 2*DATA_WIDTH = 16 bits.
TIMEOUT_CYCLES, 100000, maximum idle clocks between bytes inside a frame; 0 disables the timeout.

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous, active-high reset
s_axis_tdata  input  DATA_WIDTH  byte from uart_rx (m_axis_tdata)
s_axis_tvalid  input  1  uart_rx byte valid
s_axis_tready  output  1  controller can accept a byte
m_axis_tdata  output  DATA_WIDTH  byte to uart_tx (s_axis_tdata)
m_axis_tvalid  output  1  response byte valid
m_axis_tready  input  1  uart_tx ready
rx_frame_error_i  input  1  uart_rx frame_error
busy_o  output  1  high in any state other than IDLE
timeout_o  output  1  one-cycle pulse on inter-byte timeout abort
cmd_count_o  output  16  count of completed responses

Behaviour:
- Clocking and reset: single clock domain, clk_i. Reset is synchronous and active-high on rst_i.
  - On reset the state is IDLE.
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, busy_o=0, timeout_o=0, cmd_count_o=0.
  - The opcode, A, B, result, status and timeout counter registers all clear to 0.
  - Reset mid-frame or mid-response drops m_axis_tvalid at the next edge; the partial frame is discarded.
- FSM states: IDLE, GET_A, GET_B, EXEC, SEND_STAT, SEND_LO, SEND_HI.
- Receive handshake:
  - s_axis_tready=1 only in IDLE, GET_A and GET_B.
  - A byte is accepted on a cycle with tvalid and tready both high.
  - IDLE accepts the opcode and goes to GET_A. GET_A accepts A and goes to GET_B. GET_B accepts B and goes to EXEC.
  - In EXEC and the SEND states tready=0, so uart_rx holds or overruns as it does by design.
- EXEC (exactly 1 cycle): registers the 16-bit result and the status byte, then goes to SEND_STAT.
- Opcodes:
  - 0x00 ADD: zero-extended A+B.
  - 0x01 SUB: (A-B) mod 2^16 on zero-extended operands.
  - 0x02 AND, 0x03 OR, 0x04 XOR: 8-bit logic result, zero-extended to 16 bits.
  - 0x05 MUL: unsigned A*B.
  - Any other opcode: status=0x01, result=0x0000. Valid opcodes give status=0x00.
- Transmit handshake:
  - In SEND_STAT, SEND_LO and SEND_HI, m_axis_tvalid=1 and m_axis_tdata holds status, result[7:0] and result[15:8] respectively.
  - tdata and tvalid stay stable until m_axis_tready=1; the state then advances on that edge.
  - SEND_HI completion returns to IDLE and increments cmd_count_o; the counter wraps 0xFFFF->0x0000.
- Latency: the first response byte is valid 2 cycles after the B handshake edge (one EXEC cycle, then SEND_STAT). Back-to-back frames are allowed; IDLE accepts the next opcode in the cycle after the SEND_HI handshake.
- Timeout:
  - The counter clears on every accepted byte and on entry to IDLE. It increments each cycle in GET_A and GET_B without a handshake.
  - When the counter reaches TIMEOUT_CYCLES-1 with no handshake that cycle, the FSM goes to IDLE and timeout_o pulses for one cycle.
  - A handshake in the same cycle as the counter reaching its limit wins: the byte is accepted and there is no timeout.
- Frame error:
  - rx_frame_error_i=1 in GET_A or GET_B aborts to IDLE with no response, and any byte handshaken that cycle is discarded.
  - In IDLE, a byte arriving with rx_frame_error_i=1 is dropped and the FSM stays in IDLE.
  - In EXEC and the SEND states the frame error is ignored.
- No response is produced for an aborted frame, and cmd_count_o is unchanged.

Test Plan:
- ADD with carry: rx 0x00,0xFF,0x01 -> tx 0x00,0x00,0x01; cmd_count_o=1; first tvalid 2 cycles after the B handshake.
- MUL and SUB: rx 0x05,0xFF,0xFF -> tx 0x00,0x01,0xFE; rx 0x01,0x00,0x01 -> tx 0x00,0xFF,0xFF; cmd_count_o=2.
- Bad opcode: rx 0x7F,0x12,0x34 -> tx 0x01,0x00,0x00; cmd_count_o increments.
- Backpressure: m_axis_tready held low 5 cycles during SEND_LO -> m_axis_tdata stays at the LO byte with tvalid=1, s_axis_tready=0 throughout, no byte lost or duplicated.
- Timeout: TIMEOUT_CYCLES=16, rx opcode 0x00 then stall -> timeout_o pulses 16 cycles later, FSM is in IDLE, no tx; next frame 0x02,0xF0,0x3C -> tx 0x00,0x30,0x00.
- Frame error and reset: rx 0x00,0x11 then a B byte with rx_frame_error_i=1 -> no tx, IDLE. Separately, assert rst_i during SEND_STAT -> tvalid=0 and cmd_count_o=0 on the next edge.

Source files
------------

// File: rtl/alu_cmd_ctrl.sv
// Command sequencer for the UART ALU.
// Collects a 3-byte command frame (opcode, A, B) from uart_rx, runs one ALU
// operation and streams a 3-byte response (status, result_lo, result_hi) to
// uart_tx. It also provides an inter-byte timeout, a frame-error abort and a
// count of completed commands.
module alu_cmd_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rx_frame_error_i,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic [15:0]           cmd_count_o
);

  localparam int unsigned RW          = 2 * DATA_WIDTH;
  localparam int unsigned CW          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TO_LAST   = CW'(TO_LAST_INT);
  localparam bit          TO_EN       = (TIMEOUT_CYCLES != 0);

  localparam logic [DATA_WIDTH-1:0] OP_ADD    = DATA_WIDTH'(0);
  localparam logic [DATA_WIDTH-1:0] OP_SUB    = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] OP_AND    = DATA_WIDTH'(2);
  localparam logic [DATA_WIDTH-1:0] OP_OR     = DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] OP_XOR    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] OP_MUL    = DATA_WIDTH'(5);
  localparam logic [DATA_WIDTH-1:0] ST_OK     = DATA_WIDTH'(0);
  localparam logic [DATA_WIDTH-1:0] ST_BAD_OP = DATA_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    EXEC,
    SEND_STAT,
    SEND_LO,
    SEND_HI
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_op;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [RW-1:0]         r_result;
  logic [DATA_WIDTH-1:0] r_status;
  logic [CW-1:0]         r_to_cnt;
  logic                  r_s_tready;
  logic                  r_m_tvalid;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_busy;
  logic                  r_timeout;
  logic [15:0]           r_cmd_count;

  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_op_nxt;
  logic [DATA_WIDTH-1:0] w_a_nxt;
  logic [DATA_WIDTH-1:0] w_b_nxt;
  logic [RW-1:0]         w_result_nxt;
  logic [DATA_WIDTH-1:0] w_status_nxt;
  logic [CW-1:0]         w_to_nxt;
  logic                  w_timeout_nxt;
  logic [15:0]           w_count_nxt;
  logic [DATA_WIDTH-1:0] w_tdata_nxt;
  logic [RW-1:0]         w_alu_result;
  logic [DATA_WIDTH-1:0] w_alu_status;
  logic                  w_s_hs;
  logic                  w_m_hs;

  assign w_s_hs = s_axis_tvalid & r_s_tready;
  assign w_m_hs = r_m_tvalid & m_axis_tready;

  // ALU: evaluates the captured frame; consumed only in EXEC
  always_comb begin
    w_alu_result = '0;
    w_alu_status = ST_OK;
    case (r_op)
      OP_ADD:  w_alu_result = RW'(r_a) + RW'(r_b);
      OP_SUB:  w_alu_result = RW'(r_a) - RW'(r_b);
      OP_AND:  w_alu_result = RW'(r_a & r_b);
      OP_OR:   w_alu_result = RW'(r_a | r_b);
      OP_XOR:  w_alu_result = RW'(r_a ^ r_b);
      OP_MUL:  w_alu_result = RW'(r_a) * RW'(r_b);
      default: begin
        w_alu_result = '0;
        w_alu_status = ST_BAD_OP;
      end
    endcase
  end

  // Next-state and datapath update; frame error beats handshake beats timeout
  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_result_nxt  = r_result;
    w_status_nxt  = r_status;
    w_to_nxt      = r_to_cnt;
    w_timeout_nxt = 1'b0;
    w_count_nxt   = r_cmd_count;
    case (r_state)
      IDLE: begin
        w_to_nxt = '0;
        if (w_s_hs && !rx_frame_error_i) begin
          w_op_nxt    = s_axis_tdata;
          w_state_nxt = GET_A;
        end
      end
      GET_A, GET_B: begin
        if (rx_frame_error_i) begin
          w_state_nxt = IDLE;
          w_to_nxt    = '0;
        end else if (w_s_hs) begin
          w_to_nxt = '0;
          if (r_state == GET_A) begin
            w_a_nxt     = s_axis_tdata;
            w_state_nxt = GET_B;
          end else begin
            w_b_nxt     = s_axis_tdata;
            w_state_nxt = EXEC;
          end
        end else if (TO_EN && (r_to_cnt == TO_LAST)) begin
          w_state_nxt   = IDLE;
          w_to_nxt      = '0;
          w_timeout_nxt = 1'b1;
        end else if (TO_EN) begin
          w_to_nxt = r_to_cnt + CW'(1);
        end
      end
      EXEC: begin
        w_result_nxt = w_alu_result;
        w_status_nxt = w_alu_status;
        w_state_nxt  = SEND_STAT;
      end
      SEND_STAT: if (w_m_hs) w_state_nxt = SEND_LO;
      SEND_LO:   if (w_m_hs) w_state_nxt = SEND_HI;
      SEND_HI: begin
        if (w_m_hs) begin
          w_state_nxt = IDLE;
          w_count_nxt = r_cmd_count + 16'd1;
          w_to_nxt    = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output byte is chosen from the next state so tdata is registered with tvalid
  always_comb begin
    w_tdata_nxt = '0;
    case (w_state_nxt)
      SEND_STAT: w_tdata_nxt = w_status_nxt;
      SEND_LO:   w_tdata_nxt = w_result_nxt[DATA_WIDTH-1:0];
      SEND_HI:   w_tdata_nxt = w_result_nxt[RW-1:DATA_WIDTH];
      default:   w_tdata_nxt = '0;
    endcase
  end

  // State, datapath and registered handshake/status outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_status    <= '0;
      r_to_cnt    <= '0;
      r_s_tready  <= 1'b0;
      r_m_tvalid  <= 1'b0;
      r_m_tdata   <= '0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_cmd_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_result    <= w_result_nxt;
      r_status    <= w_status_nxt;
      r_to_cnt    <= w_to_nxt;
      r_s_tready  <= (w_state_nxt == IDLE) || (w_state_nxt == GET_A) || (w_state_nxt == GET_B);
      r_m_tvalid  <= (w_state_nxt == SEND_STAT) || (w_state_nxt == SEND_LO) ||
                     (w_state_nxt == SEND_HI);
      r_m_tdata   <= w_tdata_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_timeout   <= w_timeout_nxt;
      r_cmd_count <= w_count_nxt;
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign busy_o        = r_busy;
  assign timeout_o     = r_timeout;
  assign cmd_count_o   = r_cmd_count;

endmodule
